// File: rtl/vga_fb_arbiter.sv
// Arbitrates one single-port framebuffer RAM between VGA scanout and a CPU port.
// Optional macro VGA_FB_CPU_READ_EN enables CPU reads; without it reads are accepted but ignored.
module vga_fb_arbiter #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  // sync generator side
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              video_on_in,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              video_on_out,
  output logic [DATA_W-1:0] pixel,
  // CPU load/store port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // framebuffer RAM side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] FB_WORDS = (ADDR_W + 1)'(FB_W * FB_H);

`ifdef VGA_FB_CPU_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic              disp_slot;
  logic              cpu_accept;
  logic              cpu_in_range;
  logic              cpu_mem_go;
  logic [ADDR_W-1:0] disp_addr;

  // One framebuffer fetch per 2^SCALE_SHIFT visible pixels, at the left edge of each block.
  assign disp_slot    = video_on_in && (x[SCALE_SHIFT-1:0] == '0);
  assign cpu_ready    = !disp_slot;
  assign cpu_accept   = cpu_req && cpu_ready;
  assign cpu_in_range = {1'b0, cpu_addr} < FB_WORDS;
  assign cpu_mem_go   = cpu_accept && cpu_in_range && (cpu_we || READ_EN);

  assign disp_addr = ADDR_W'(y >> SCALE_SHIFT) * ADDR_W'(FB_W) + ADDR_W'(x >> SCALE_SHIFT);

  always_comb begin
    // NOTE: every output gets a default before the branches so no latch is inferred.
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_slot) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (cpu_mem_go) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Two-stage delay keeps syncs aligned with the RAM latency plus the pixel register.
  logic [1:0] hsync_d;
  logic [1:0] vsync_d;
  logic [1:0] video_on_d;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      hsync_d    <= 2'b11;
      vsync_d    <= 2'b11;
      video_on_d <= 2'b00;
    end else begin
      hsync_d    <= {hsync_d[0], hsync_in};
      vsync_d    <= {vsync_d[0], vsync_in};
      video_on_d <= {video_on_d[0], video_on_in};
    end
  end

  assign hsync_out    = hsync_d[1];
  assign vsync_out    = vsync_d[1];
  assign video_on_out = video_on_d[1];

  logic              disp_pend;
  logic [DATA_W-1:0] pixel_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_pend <= 1'b0;
      pixel_q   <= '0;
    end else begin
      disp_pend <= disp_slot;
      if (disp_pend) begin
        pixel_q <= mem_rdata;
      end
    end
  end

  assign pixel = video_on_out ? pixel_q : '0;

`ifdef VGA_FB_CPU_READ_EN
  // Out-of-range reads still produce a response, with zero data.
  logic cpu_pend;
  logic cpu_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_pend <= 1'b0;
      cpu_zero <= 1'b0;
    end else begin
      cpu_pend <= cpu_accept && !cpu_we;
      cpu_zero <= !cpu_in_range;
    end
  end

  assign cpu_rvalid = cpu_pend;
  assign cpu_rdata  = (cpu_pend && !cpu_zero) ? mem_rdata : '0;
`else
  assign cpu_rvalid = 1'b0;
  assign cpu_rdata  = '0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: decode vectors, directed corner sequences,
// and a randomized raster with CPU traffic checked against a framebuffer-level model.
module tb_vga_fb_arbiter;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int AW       = 15;
  localparam int DW       = 8;
  localparam int FB_WORDS = FB_W * FB_H;

`ifdef VGA_FB_CPU_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [9:0]    x, y;
  logic          hsync_in, vsync_in, video_on_in;
  logic          hsync_out, vsync_out, video_on_out;
  logic [DW-1:0] pixel;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  vga_fb_arbiter #(
    .FB_W(FB_W), .FB_H(FB_H), .SCALE_SHIFT(2), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk(clk), .reset(reset),
    .x(x), .y(y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on_in(video_on_in),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .video_on_out(video_on_out),
    .pixel(pixel),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer RAM: single port, one cycle read latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;
  logic          load_pattern;

  function automatic logic [DW-1:0] pattern(int i);
    return DW'((i + 1) * 17);
  endfunction

  always @(posedge clk) begin
    if (load_pattern) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= pattern(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        rd_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = rd_q;

  logic [DW-1:0] shadow [0:FB_WORDS-1];
  int n_checks, n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    video_on_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    x = '0; y = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic load();
    tick();
    load_pattern = 1'b1;
    tick();
    load_pattern = 1'b0;
    for (int i = 0; i < FB_WORDS; i++) shadow[i] = pattern(i);
  endtask

  typedef struct {
    logic          vo;
    logic [9:0]    vx, vy;
    logic          req, we;
    logic [AW-1:0] addr;
    logic          ready, en, mwe;
    logic [AW-1:0] maddr;
  } vec_t;

  typedef struct {
    logic          vo, hs, vs;
    logic [DW-1:0] pix;
  } hist_t;

  vec_t vecs [12];

  initial begin
    logic          exp_en, exp_we, slot, acc, inr, exp_rv;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_rd, blk;
    logic          r_hold, r_req, r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          vo, hs, vs;
    hist_t         h1, h2;
    int            ly, idx, errs;

    n_checks = 0; n_pass = 0;
    load_pattern = 1'b0;
    reset = 1'b1;
    set_idle();

    //            vo    x        y        req   we    addr       ready en    mwe   maddr
    vecs[0]  = '{1'b1, 10'd0,   10'd0,   1'b0, 1'b0, 15'd0,     1'b0, 1'b1, 1'b0, 15'd0};
    vecs[1]  = '{1'b1, 10'd4,   10'd0,   1'b0, 1'b0, 15'd0,     1'b0, 1'b1, 1'b0, 15'd1};
    vecs[2]  = '{1'b1, 10'd1,   10'd0,   1'b1, 1'b1, 15'd5,     1'b1, 1'b1, 1'b1, 15'd5};
    vecs[3]  = '{1'b1, 10'd0,   10'd0,   1'b1, 1'b1, 15'd5,     1'b0, 1'b1, 1'b0, 15'd0};
    vecs[4]  = '{1'b0, 10'd0,   10'd0,   1'b1, 1'b0, 15'd2,     1'b1, 1'b1, 1'b0, 15'd2};
    vecs[5]  = '{1'b1, 10'd636, 10'd479, 1'b0, 1'b0, 15'd0,     1'b0, 1'b1, 1'b0, 15'd19199};
    vecs[6]  = '{1'b1, 10'd8,   10'd4,   1'b1, 1'b1, 15'd7,     1'b0, 1'b1, 1'b0, 15'd162};
    vecs[7]  = '{1'b0, 10'd100, 10'd500, 1'b0, 1'b0, 15'd0,     1'b1, 1'b0, 1'b0, 15'd0};
    vecs[8]  = '{1'b1, 10'd2,   10'd0,   1'b1, 1'b1, 15'd19200, 1'b1, 1'b0, 1'b0, 15'd0};
    vecs[9]  = '{1'b1, 10'd3,   10'd0,   1'b0, 1'b0, 15'd0,     1'b1, 1'b0, 1'b0, 15'd0};
    vecs[10] = '{1'b1, 10'd639, 10'd0,   1'b1, 1'b1, 15'd32767, 1'b1, 1'b0, 1'b0, 15'd0};
    vecs[11] = '{1'b1, 10'd5,   10'd9,   1'b1, 1'b0, 15'd19199, 1'b1, 1'b1, 1'b0, 15'd19199};

    load();

    // Reset holds outputs at their idle values even with active inputs.
    video_on_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (3) tick();
    #1;
    check("reset_pixel", pixel, 0);
    check("reset_hsync_out", hsync_out, 1);
    check("reset_vsync_out", vsync_out, 1);
    check("reset_video_on_out", video_on_out, 0);
    check("reset_rvalid", cpu_rvalid, 0);
    check("reset_rdata", cpu_rdata, 0);
    reset = 1'b0;
    set_idle();
    repeat (3) tick();

    // Slot decode vectors.
    for (int i = 0; i < 12; i++) begin
      tick();
      video_on_in = vecs[i].vo; x = vecs[i].vx; y = vecs[i].vy;
      cpu_req = vecs[i].req; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_wdata = 8'h5A;
      #1;
      exp_en = vecs[i].en;
      if (vecs[i].req && !vecs[i].we && vecs[i].ready && !READ_EN) exp_en = 1'b0;
      check($sformatf("vec%0d_ready", i), cpu_ready, vecs[i].ready);
      check($sformatf("vec%0d_mem_en", i), mem_en, exp_en);
      check($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].mwe);
      if (exp_en) check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].maddr);
    end
    set_idle();
    load();

    // Scanout of one visible line segment.
    for (int i = 0; i < 12; i++) begin
      tick();
      y = '0; x = 10'(i); video_on_in = (i < 8);
      #1;
      if (i == 0) check("scan_addr_x0", mem_addr, 0);
      if (i == 4) check("scan_addr_x4", mem_addr, 1);
      if (i >= 2) check($sformatf("scan_pixel_t%0d", i), pixel,
                        (i - 2) < 4 ? 8'h11 : ((i - 2) < 8 ? 8'h22 : 8'h00));
    end

    // CPU write held across a display slot.
    for (int i = 0; i < 4; i++) begin
      tick();
      y = '0; x = 10'(i); video_on_in = 1'b1;
      cpu_req = (i < 2); cpu_we = 1'b1; cpu_addr = 15'd5; cpu_wdata = 8'hAB;
      #1;
      if (i == 0) begin
        check("wr_ready_x0", cpu_ready, 0);
        check("wr_mem_we_x0", mem_we, 0);
      end
      if (i == 1) begin
        check("wr_ready_x1", cpu_ready, 1);
        check("wr_mem_we_x1", mem_we, 1);
        check("wr_mem_addr_x1", mem_addr, 5);
        check("wr_mem_wdata_x1", mem_wdata, 8'hAB);
      end
    end
    shadow[5] = 8'hAB;
    tick();
    set_idle();
    tick();
    check("wr_ram5", ram[5], 8'hAB);
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd5;
    tick();
    cpu_req = 1'b0;
    #1;
    check("rd5_rvalid", cpu_rvalid, READ_EN);
    check("rd5_rdata", cpu_rdata, READ_EN ? 8'hAB : 8'h00);

    // Back-to-back reads during blanking.
    for (int k = 0; k < 5; k++) begin
      tick();
      cpu_req = (k < 3); cpu_we = 1'b0; cpu_addr = AW'(k);
      #1;
      if (k >= 1 && k <= 3) begin
        check($sformatf("b2b_rvalid%0d", k - 1), cpu_rvalid, READ_EN);
        check($sformatf("b2b_rdata%0d", k - 1), cpu_rdata, READ_EN ? shadow[k - 1] : 8'h00);
      end
      if (k == 4) check("b2b_rvalid_end", cpu_rvalid, 0);
      check("b2b_pixel", pixel, 0);
    end

    // Out-of-range read and write.
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd19200;
    #1;
    check("oor_rd_mem_en", mem_en, 0);
    check("oor_rd_ready", cpu_ready, 1);
    tick();
    cpu_we = 1'b1; cpu_addr = 15'd19201; cpu_wdata = 8'hEE;
    #1;
    check("oor_rvalid", cpu_rvalid, READ_EN);
    check("oor_rdata", cpu_rdata, 0);
    check("oor_wr_mem_en", mem_en, 0);
    tick();
    set_idle();

    // Read accepted in the same cycle reset is asserted.
    tick();
    reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd1;
    tick();
    reset = 1'b0; cpu_req = 1'b0;
    #1;
    check("rst_rd_rvalid", cpu_rvalid, 0);
    tick();
    check("rst_rd_rvalid_late", cpu_rvalid, 0);

    // Randomized raster with CPU traffic.
    set_idle();
    repeat (3) tick();
    h1 = '{1'b0, 1'b1, 1'b1, 8'h00};
    h2 = h1;
    blk = '0; exp_rv = 1'b0; exp_rd = '0;
    r_hold = 1'b0; r_req = 1'b0; r_we = 1'b0; r_addr = '0; r_wdata = '0;
    for (int line = 0; line < 12; line++) begin
      ly = $urandom_range(0, 524);
      for (int xi = 0; xi < 100; xi++) begin
        tick();
        if (!r_hold) begin
          r_req = 1'($urandom_range(0, 1));
          r_we  = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 7) == 0) r_addr = AW'($urandom_range(FB_WORDS, 32767));
          else r_addr = AW'(((ly / 4) % FB_H) * FB_W + $urandom_range(0, 31));
          r_wdata = DW'($urandom);
        end
        vo = (xi < 80) && (ly < 480);
        hs = !(xi >= 84 && xi < 92);
        vs = !(ly == 490 || ly == 491);
        x = 10'(xi); y = 10'(ly); video_on_in = vo; hsync_in = hs; vsync_in = vs;
        cpu_req = r_req; cpu_we = r_we; cpu_addr = r_addr; cpu_wdata = r_wdata;
        #1;
        slot = vo && (xi % 4 == 0);
        acc  = r_req && !slot;
        inr  = r_addr < FB_WORDS;
        idx  = (ly / 4) * FB_W + xi / 4;
        exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0;
        if (slot) begin
          exp_en = 1'b1; exp_addr = AW'(idx);
        end else if (acc && inr && (r_we || READ_EN)) begin
          exp_en = 1'b1; exp_we = r_we; exp_addr = r_addr;
        end
        check("rnd_ready", cpu_ready, !slot);
        check("rnd_mem_en", mem_en, exp_en);
        check("rnd_mem_we", mem_we, exp_we);
        if (exp_en) check("rnd_mem_addr", mem_addr, exp_addr);
        if (exp_en && exp_we) check("rnd_mem_wdata", mem_wdata, r_wdata);
        check("rnd_pixel", pixel, h2.vo ? h2.pix : 8'h00);
        check("rnd_hsync_out", hsync_out, h2.hs);
        check("rnd_vsync_out", vsync_out, h2.vs);
        check("rnd_video_on_out", video_on_out, h2.vo);
        check("rnd_rvalid", cpu_rvalid, exp_rv);
        check("rnd_rdata", cpu_rdata, exp_rd);
        if (slot) blk = shadow[idx];
        h2 = h1;
        h1 = '{vo, hs, vs, blk};
        exp_rv = acc && !r_we && READ_EN;
        exp_rd = (exp_rv && inr) ? shadow[r_addr] : 8'h00;
        if (acc && r_we && inr) shadow[r_addr] = r_wdata;
        r_hold = r_req && !acc;
      end
    end
    set_idle();
    repeat (2) tick();

    errs = 0;
    for (int i = 0; i < FB_WORDS; i++) if (ram[i] !== shadow[i]) errs++;
    check("ram_image_mismatches", errs, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
